// File: rtl/elm_seq_pkg.sv
// elm_seq_pkg: shared types and defaults for the ELM layer sequencer.
//   seq_state_e    - sequencer FSM states
//   Def*           - default layer dimensions and watchdog limit
//   cfg_num_width  - width of config_layer_num / config_neuron_num (2*DATA_WIDTH+1)
//   cnt_width      - counter width able to index 0..n-1 (minimum 1 bit)
package elm_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoadW,
    StLoadB,
    StRun,
    StWait,
    StDrain
  } seq_state_e;

  localparam int unsigned DefNumNeuron     = 32;
  localparam int unsigned DefNumWeight     = 128;
  localparam int unsigned DefTimeoutCycles = 1024;

  function automatic int unsigned cfg_num_width(input int unsigned data_width);
    return 2 * data_width + 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/elm_layer_sequencer_if.sv
// elm_layer_sequencer_if: the three valid/ready streams around the sequencer.
//   cfg_*  - weight/bias configuration stream (upstream -> sequencer)
//   in_*   - input vector stream (upstream -> sequencer)
//   out_*  - activation stream (sequencer -> next layer)
// Modports: master = stream adapters / next layer side, slave = sequencer side.
interface elm_layer_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned OUT_WIDTH  = 16
) ();

  logic                  cfg_valid;
  logic [DATA_WIDTH-1:0] cfg_data;
  logic                  cfg_ready;

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;

  logic                  out_valid;
  logic                  out_last;
  logic [OUT_WIDTH-1:0]  out_data;
  logic                  out_ready;

  modport master (
    output cfg_valid, cfg_data, in_valid, in_data, out_ready,
    input  cfg_ready, in_ready, out_valid, out_last, out_data
  );

  modport slave (
    input  cfg_valid, cfg_data, in_valid, in_data, out_ready,
    output cfg_ready, in_ready, out_valid, out_last, out_data
  );

endinterface

// File: rtl/elm_out_collector.sv
// elm_out_collector: sticky done mask, per-neuron capture registers and the
// in-order serialiser that drains the captures onto the activation stream.
//   capture_en        - high while the sequencer waits for neuron results
//   drain_en          - high while the sequencer drains captures
//   clear             - drop mask and drain index (abort / timeout)
//   neuron_out_valid/neuron_out - neuron array results
//   out_valid/out_last/out_data/out_ready - activation stream
//   mask_full         - every neuron has reported
//   drain_done        - final word handshaken this cycle
module elm_out_collector import elm_seq_pkg::*; #(
  parameter int unsigned NUM_NEURON = DefNumNeuron,
  parameter int unsigned OUT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            capture_en,
  input  logic                            drain_en,
  input  logic                            clear,
  input  logic [NUM_NEURON-1:0]           neuron_out_valid,
  input  logic [NUM_NEURON*OUT_WIDTH-1:0] neuron_out,
  input  logic                            out_ready,
  output logic                            out_valid,
  output logic                            out_last,
  output logic [OUT_WIDTH-1:0]            out_data,
  output logic                            mask_full,
  output logic                            drain_done
);

  localparam int unsigned NCW = cnt_width(NUM_NEURON);

  logic [NUM_NEURON-1:0] mask_q;
  logic [OUT_WIDTH-1:0]  cap_q [NUM_NEURON];
  logic [NCW-1:0]        idx_q;

  assign mask_full  = &mask_q;
  assign out_valid  = drain_en;
  assign out_last   = drain_en && (idx_q == NCW'(NUM_NEURON - 1));
  assign out_data   = cap_q[idx_q];
  assign drain_done = out_valid && out_ready && out_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= '0;
      idx_q  <= '0;
      for (int i = 0; i < int'(NUM_NEURON); i++) cap_q[i] <= '0;
    end else if (clear || drain_done) begin
      mask_q <= '0;
      idx_q  <= '0;
    end else begin
      if (capture_en) begin
        for (int i = 0; i < int'(NUM_NEURON); i++) begin
          if (neuron_out_valid[i]) begin
            mask_q[i] <= 1'b1;
            cap_q[i]  <= neuron_out[i*OUT_WIDTH +: OUT_WIDTH];
          end
        end
      end
      if (drain_en && out_ready) idx_q <= idx_q + 1'b1;
    end
  end

endmodule

// File: rtl/elm_layer_sequencer.sv
// elm_layer_sequencer: controller for one ELM hidden layer.
// Loads weights (neuron-major) then biases over the cfg stream, forwards
// NUM_WEIGHT input words per inference, waits for all neurons and drains
// the activations in neuron order.
//   clk, rst           - clock, asynchronous active-high reset
//   start_load/start_infer/abort - command pulses
//   bus (slave)        - cfg / in / out streams
//   weight_*/bias_*/neuron_in*/config_* - broadcast bus to the neuron array
//   neuron_out_valid/neuron_out - neuron array results
//   busy, load_done, err - status
// Optional: define ELM_SEQ_TIMEOUT_EN to add the WAIT watchdog driving err.
module elm_layer_sequencer import elm_seq_pkg::*; #(
  parameter int unsigned LAYER_NO       = 1,
  parameter int unsigned NUM_NEURON     = DefNumNeuron,
  parameter int unsigned NUM_WEIGHT     = DefNumWeight,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned OUT_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start_load,
  input  logic                            start_infer,
  input  logic                            abort,
  elm_layer_sequencer_if.slave            bus,
  output logic                            weight_valid,
  output logic [NUM_NEURON-1:0]           bias_valid,
  output logic                            neuron_in_valid,
  output logic [DATA_WIDTH-1:0]           weight_value,
  output logic [DATA_WIDTH-1:0]           bias_value,
  output logic [DATA_WIDTH-1:0]           neuron_in,
  output logic [2*DATA_WIDTH:0]           config_layer_num,
  output logic [2*DATA_WIDTH:0]           config_neuron_num,
  input  logic [NUM_NEURON-1:0]           neuron_out_valid,
  input  logic [NUM_NEURON*OUT_WIDTH-1:0] neuron_out,
  output logic                            busy,
  output logic                            load_done,
  output logic                            err
);

  localparam int unsigned NCW  = cnt_width(NUM_NEURON);
  localparam int unsigned WCW  = cnt_width(NUM_WEIGHT);
  localparam int unsigned CfgW = cfg_num_width(DATA_WIDTH);

  seq_state_e            state_q, state_d;
  logic [NCW-1:0]        n_cnt_q, n_cnt_d;
  logic [WCW-1:0]        w_cnt_q, w_cnt_d;
  logic                  load_done_q, load_done_d;
  logic                  weight_valid_q, weight_valid_d;
  logic [NUM_NEURON-1:0] bias_valid_q, bias_valid_d;
  logic                  neuron_in_valid_q, neuron_in_valid_d;
  logic [DATA_WIDTH-1:0] weight_value_q, weight_value_d;
  logic [DATA_WIDTH-1:0] bias_value_q, bias_value_d;
  logic [DATA_WIDTH-1:0] neuron_in_q, neuron_in_d;
  logic [CfgW-1:0]       cfg_neuron_q, cfg_neuron_d;
  logic                  clear;
  logic                  mask_full, drain_done;
  logic                  cfg_hs, in_hs;
  logic                  last_w, last_n;

`ifdef ELM_SEQ_TIMEOUT_EN
  localparam int unsigned ToW = cnt_width(TIMEOUT_CYCLES);
  logic [ToW-1:0] tout_q, tout_d;
  logic           err_q, err_d;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign bus.cfg_ready     = (state_q == StLoadW) || (state_q == StLoadB);
  assign bus.in_ready      = (state_q == StRun);
  assign busy              = (state_q != StIdle);
  assign cfg_hs            = bus.cfg_valid && bus.cfg_ready;
  assign in_hs             = bus.in_valid && bus.in_ready;
  assign last_w            = (w_cnt_q == WCW'(NUM_WEIGHT - 1));
  assign last_n            = (n_cnt_q == NCW'(NUM_NEURON - 1));

  assign load_done         = load_done_q;
  assign weight_valid      = weight_valid_q;
  assign bias_valid        = bias_valid_q;
  assign neuron_in_valid   = neuron_in_valid_q;
  assign weight_value      = weight_value_q;
  assign bias_value        = bias_value_q;
  assign neuron_in         = neuron_in_q;
  assign config_neuron_num = cfg_neuron_q;
  assign config_layer_num  = CfgW'(LAYER_NO);

  always_comb begin
    state_d           = state_q;
    n_cnt_d           = n_cnt_q;
    w_cnt_d           = w_cnt_q;
    load_done_d       = load_done_q;
    weight_valid_d    = 1'b0;
    bias_valid_d      = '0;
    neuron_in_valid_d = 1'b0;
    weight_value_d    = weight_value_q;
    bias_value_d      = bias_value_q;
    neuron_in_d       = neuron_in_q;
    cfg_neuron_d      = cfg_neuron_q;
    clear             = 1'b0;
`ifdef ELM_SEQ_TIMEOUT_EN
    tout_d            = tout_q;
    err_d             = err_q;
`endif
    if (abort) begin
      // Abort beats any handshake in the same cycle: no strobe is emitted.
      state_d = StIdle;
      n_cnt_d = '0;
      w_cnt_d = '0;
      clear   = 1'b1;
`ifdef ELM_SEQ_TIMEOUT_EN
      tout_d  = '0;
`endif
      if ((state_q == StLoadW) || (state_q == StLoadB)) load_done_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_load) begin
            state_d     = StLoadW;
            load_done_d = 1'b0;
            n_cnt_d     = '0;
            w_cnt_d     = '0;
`ifdef ELM_SEQ_TIMEOUT_EN
            err_d       = 1'b0;
`endif
          end else if (start_infer && load_done_q) begin
            state_d = StRun;
            w_cnt_d = '0;
          end
        end
        StLoadW: begin
          if (cfg_hs) begin
            weight_value_d = bus.cfg_data;
            weight_valid_d = 1'b1;
            cfg_neuron_d   = CfgW'(n_cnt_q);
            if (last_w) begin
              w_cnt_d = '0;
              if (last_n) begin
                n_cnt_d = '0;
                state_d = StLoadB;
              end else begin
                n_cnt_d = n_cnt_q + 1'b1;
              end
            end else begin
              w_cnt_d = w_cnt_q + 1'b1;
            end
          end
        end
        StLoadB: begin
          if (cfg_hs) begin
            bias_value_d          = bus.cfg_data;
            bias_valid_d[n_cnt_q] = 1'b1;
            cfg_neuron_d          = CfgW'(n_cnt_q);
            if (last_n) begin
              n_cnt_d     = '0;
              state_d     = StIdle;
              load_done_d = 1'b1;
            end else begin
              n_cnt_d = n_cnt_q + 1'b1;
            end
          end
        end
        StRun: begin
          if (in_hs) begin
            neuron_in_d       = bus.in_data;
            neuron_in_valid_d = 1'b1;
            if (last_w) begin
              w_cnt_d = '0;
              state_d = StWait;
`ifdef ELM_SEQ_TIMEOUT_EN
              tout_d  = '0;
`endif
            end else begin
              w_cnt_d = w_cnt_q + 1'b1;
            end
          end
        end
        StWait: begin
          if (mask_full) begin
            state_d = StDrain;
`ifdef ELM_SEQ_TIMEOUT_EN
          end else if (tout_q == ToW'(TIMEOUT_CYCLES - 1)) begin
            state_d = StIdle;
            err_d   = 1'b1;
            clear   = 1'b1;
            tout_d  = '0;
          end else begin
            tout_d = tout_q + 1'b1;
`endif
          end
        end
        StDrain: begin
          if (drain_done) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= StIdle;
      n_cnt_q           <= '0;
      w_cnt_q           <= '0;
      load_done_q       <= 1'b0;
      weight_valid_q    <= 1'b0;
      bias_valid_q      <= '0;
      neuron_in_valid_q <= 1'b0;
      weight_value_q    <= '0;
      bias_value_q      <= '0;
      neuron_in_q       <= '0;
      cfg_neuron_q      <= '0;
`ifdef ELM_SEQ_TIMEOUT_EN
      tout_q            <= '0;
      err_q             <= 1'b0;
`endif
    end else begin
      state_q           <= state_d;
      n_cnt_q           <= n_cnt_d;
      w_cnt_q           <= w_cnt_d;
      load_done_q       <= load_done_d;
      weight_valid_q    <= weight_valid_d;
      bias_valid_q      <= bias_valid_d;
      neuron_in_valid_q <= neuron_in_valid_d;
      weight_value_q    <= weight_value_d;
      bias_value_q      <= bias_value_d;
      neuron_in_q       <= neuron_in_d;
      cfg_neuron_q      <= cfg_neuron_d;
`ifdef ELM_SEQ_TIMEOUT_EN
      tout_q            <= tout_d;
      err_q             <= err_d;
`endif
    end
  end

  elm_out_collector #(
    .NUM_NEURON (NUM_NEURON),
    .OUT_WIDTH  (OUT_WIDTH)
  ) u_collector (
    .clk              (clk),
    .rst              (rst),
    .capture_en       (state_q == StWait),
    .drain_en         (state_q == StDrain),
    .clear            (clear),
    .neuron_out_valid (neuron_out_valid),
    .neuron_out       (neuron_out),
    .out_ready        (bus.out_ready),
    .out_valid        (bus.out_valid),
    .out_last         (bus.out_last),
    .out_data         (bus.out_data),
    .mask_full        (mask_full),
    .drain_done       (drain_done)
  );

endmodule

// File: tb/tb_elm_layer_sequencer.sv
// tb_elm_layer_sequencer: self-checking bench for elm_layer_sequencer with
// NUM_NEURON=4, NUM_WEIGHT=8, TIMEOUT_CYCLES=16. Inputs are driven and
// outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_elm_layer_sequencer;

  localparam int unsigned NN = 4;
  localparam int unsigned NW = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned OW = 16;
  localparam int unsigned TO = 16;
  localparam int unsigned LN = 3;
  localparam int unsigned NT = NN * NW + NN;

  typedef struct {
    logic [DW-1:0] data;
    logic          is_bias;
    int unsigned   nrn;
  } cfg_vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_load = 1'b0, start_infer = 1'b0, abort = 1'b0;
  logic              weight_valid, neuron_in_valid, busy, load_done, err;
  logic [NN-1:0]     bias_valid;
  logic [DW-1:0]     weight_value, bias_value, neuron_in;
  logic [2*DW:0]     config_layer_num, config_neuron_num;
  logic [NN-1:0]     neuron_out_valid = '0;
  logic [NN*OW-1:0]  neuron_out = '0;

  int n_cmp  = 0;
  int n_fail = 0;

  cfg_vec_t      cfg_tab [NT];
  logic [OW-1:0] outs [NN];

  always #5 clk = ~clk;

  elm_layer_sequencer_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) bus ();

  elm_layer_sequencer #(
    .LAYER_NO       (LN),
    .NUM_NEURON     (NN),
    .NUM_WEIGHT     (NW),
    .DATA_WIDTH     (DW),
    .OUT_WIDTH      (OW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start_load        (start_load),
    .start_infer       (start_infer),
    .abort             (abort),
    .bus               (bus),
    .weight_valid      (weight_valid),
    .bias_valid        (bias_valid),
    .neuron_in_valid   (neuron_in_valid),
    .weight_value      (weight_value),
    .bias_value        (bias_value),
    .neuron_in         (neuron_in),
    .config_layer_num  (config_layer_num),
    .config_neuron_num (config_neuron_num),
    .neuron_out_valid  (neuron_out_valid),
    .neuron_out        (neuron_out),
    .busy              (busy),
    .load_done         (load_done),
    .err               (err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse(input int which);
    @(negedge clk);
    if (which == 0) start_load = 1'b1;
    if (which == 1) start_infer = 1'b1;
    if (which == 2) abort = 1'b1;
    @(negedge clk);
    start_load  = 1'b0;
    start_infer = 1'b0;
    abort       = 1'b0;
  endtask

  // Full weight+bias load from the table, back to back, checking every strobe.
  task automatic run_load();
    logic [NN-1:0] exp_b;
    pulse(0);
    chk("load_busy", busy, 1);
    chk("load_cfg_ready", bus.cfg_ready, 1);
    chk("load_done_clr", load_done, 0);
    for (int k = 0; k <= int'(NT); k++) begin
      if (k > 0) begin
        exp_b = '0;
        if (cfg_tab[k-1].is_bias) exp_b[cfg_tab[k-1].nrn] = 1'b1;
        chk("weight_valid", weight_valid, !cfg_tab[k-1].is_bias);
        chk("bias_valid", bias_valid, exp_b);
        chk("cfg_value", cfg_tab[k-1].is_bias ? bias_value : weight_value, cfg_tab[k-1].data);
        chk("cfg_neuron_num", config_neuron_num, cfg_tab[k-1].nrn);
        chk("cfg_layer_num", config_layer_num, LN);
        chk("load_done_step", load_done, k == int'(NT));
      end
      if (k < int'(NT)) begin
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = cfg_tab[k].data;
      end else begin
        bus.cfg_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("load_end_busy", busy, 0);
    chk("load_end_done", load_done, 1);
    chk("load_end_wv", weight_valid, 0);
    chk("load_end_bv", bias_valid, 0);
  endtask

  // start_infer then NW words back to back; returns with the DUT in WAIT.
  task automatic feed_all();
    pulse(1);
    for (int j = 0; j < int'(NW); j++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(16'h0300 + j);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    logic [13:0]   pat;
    logic          exp_v;
    logic [DW-1:0] exp_d;
    int            sent;
    int            n_pulse;

    for (int k = 0; k < int'(NN * NW); k++) begin
      cfg_tab[k].data    = DW'(16'h1000 + k);
      cfg_tab[k].is_bias = 1'b0;
      cfg_tab[k].nrn     = k / NW;
    end
    for (int b = 0; b < int'(NN); b++) begin
      cfg_tab[NN*NW+b].data    = DW'(16'hB000 + b);
      cfg_tab[NN*NW+b].is_bias = 1'b1;
      cfg_tab[NN*NW+b].nrn     = b;
    end
    for (int i = 0; i < int'(NN); i++) outs[i] = OW'(16'h5A00 + 16'h11 * i);

    bus.cfg_valid = 1'b0;
    bus.cfg_data  = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_wv", weight_valid, 0);
    chk("rst_bv", bias_valid, 0);
    chk("rst_niv", neuron_in_valid, 0);
    chk("rst_cfg_ready", bus.cfg_ready, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_err", err, 0);
    chk("rst_layer_num", config_layer_num, LN);
    chk("rst_neuron_num", config_neuron_num, 0);
    chk("rst_wvalue", weight_value, 0);
    rst = 1'b0;

    // start_infer without a prior load is ignored
    pulse(1);
    chk("noload_busy", busy, 0);
    chk("noload_in_ready", bus.in_ready, 0);

    run_load();

    // neuron_out_valid while idle must not be captured
    neuron_out_valid = '1;
    neuron_out       = {NN{16'hDEAD}};
    @(negedge clk);
    neuron_out_valid = '0;

    // Inference with gaps in in_valid, then a refused 9th word
    pulse(1);
    pat     = 14'b01_1101_1100_1101;
    exp_v   = 1'b0;
    exp_d   = '0;
    sent    = 0;
    n_pulse = 0;
    for (int c = 0; c < 14; c++) begin
      chk("niv", neuron_in_valid, exp_v);
      if (exp_v) chk("neuron_in", neuron_in, exp_d);
      if (neuron_in_valid) n_pulse++;
      chk("in_ready", bus.in_ready, sent < int'(NW));
      bus.in_valid = pat[c];
      bus.in_data  = DW'(16'h0A00 + sent);
      exp_v        = pat[c] && (sent < int'(NW));
      if (exp_v) begin
        exp_d = bus.in_data;
        sent++;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("niv_after", neuron_in_valid, 0);
    chk("niv_count", n_pulse, NW);

    // Neurons finish out of order 3,0,(gap),2,1; other slots carry junk
    for (int s = 0; s < 5; s++) begin
      int nid;
      nid = (s == 0) ? 3 : (s == 1) ? 0 : (s == 2) ? -1 : (s == 3) ? 2 : 1;
      chk("wait_busy", busy, 1);
      chk("wait_out_valid", bus.out_valid, 0);
      neuron_out       = {NN{16'hEEEE}};
      neuron_out_valid = '0;
      if (nid >= 0) begin
        neuron_out_valid[nid]         = 1'b1;
        neuron_out[nid*OW +: OW]      = outs[nid];
      end
      @(negedge clk);
    end
    neuron_out_valid = '0;
    chk("capture_cycle_ov", bus.out_valid, 0);
    @(negedge clk);

    // Drain with out_ready held low for 5 cycles
    for (int s = 0; s < 5; s++) begin
      chk("stall_ov", bus.out_valid, 1);
      chk("stall_data", bus.out_data, outs[0]);
      chk("stall_last", bus.out_last, 0);
      @(negedge clk);
    end
    for (int i = 0; i < int'(NN); i++) begin
      chk("drain_ov", bus.out_valid, 1);
      chk("drain_data", bus.out_data, outs[i]);
      chk("drain_last", bus.out_last, i == int'(NN) - 1);
      bus.out_ready = 1'b1;
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    chk("drain_end_ov", bus.out_valid, 0);
    chk("drain_end_busy", busy, 0);
    chk("drain_keep_done", load_done, 1);

    // Abort during LOAD_W after 10 words
    pulse(0);
    for (int k = 0; k < 10; k++) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = DW'(16'h7700 + k);
      @(negedge clk);
    end
    bus.cfg_valid = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_load_done", load_done, 0);
    chk("abort_wv", weight_valid, 0);
    chk("abort_cfg_ready", bus.cfg_ready, 0);
    pulse(1);
    chk("abort_noinfer", busy, 0);

    run_load();

    // Abort in WAIT keeps load_done
    feed_all();
    chk("wait_state_busy", busy, 1);
    chk("wait_in_ready", bus.in_ready, 0);
    repeat (3) @(negedge clk);
    chk("wait_err", err, 0);
    pulse(2);
    chk("abort_wait_busy", busy, 0);
    chk("abort_wait_done", load_done, 1);

`ifdef ELM_SEQ_TIMEOUT_EN
    // Neuron 3 never reports: watchdog fires after TO WAIT cycles
    feed_all();
    for (int c = 0; c <= int'(TO); c++) begin
      if (c < int'(TO)) begin
        chk("to_busy", busy, 1);
        chk("to_err_low", err, 0);
      end else begin
        chk("to_busy_end", busy, 0);
        chk("to_err", err, 1);
      end
      chk("to_no_ov", bus.out_valid, 0);
      neuron_out_valid = '0;
      if (c < 3) neuron_out_valid[c] = 1'b1;
      @(negedge clk);
    end
    neuron_out_valid = '0;
    repeat (2) @(negedge clk);
    chk("to_err_sticky", err, 1);
    chk("to_no_ov2", bus.out_valid, 0);
    pulse(0);
    chk("to_err_cleared", err, 0);
    pulse(2);
`endif

    // Reset in the middle of a load
    pulse(0);
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = 16'h4242;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_wv", weight_valid, 0);
    chk("midrst_cfg_ready", bus.cfg_ready, 0);
    chk("midrst_wvalue", weight_value, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
